// File: rtl/led_blink_arb.sv
// -----------------------------------------------------------------------------
// led_blink_arb
//
// Shares one LED among four requesters. The winner of arbitration owns the LED
// for a burst of (i+1) blink pulses, each HALF_PERIOD cycles on followed by
// HALF_PERIOD cycles off. A dark gap of GAP_CYCLES cycles follows every burst
// before the next request is considered. Requests are sampled only in IDLE.
// Once granted, the owner's req is ignored until the burst has finished.
//
// Configuration macro:
//   LED_BLINK_RR_EN  defined   -> round-robin arbitration. The search starts
//                                 at pointer+1 modulo 4, and the pointer moves
//                                 to the winner at each grant.
//                    undefined -> fixed priority, req[0] highest.
//
// Parameters:
//   HALF_PERIOD  cycles per LED on phase and per off phase (>= 1)
//   GAP_CYCLES   cycles of dark gap after each burst (>= 1)
//
// Ports:
//   clk    in   system clock, all logic on posedge
//   rst    in   asynchronous active-high reset
//   req    in   [3:0] burst request; requester i asks for i+1 pulses
//   grant  out  [3:0] one-hot LED owner, zero when there is no owner
//   done   out  [3:0] one-cycle completion pulse to the owner
//   led    out  LED drive, high = on
//   busy   out  high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module led_blink_arb #(
    parameter int unsigned HALF_PERIOD = 25000000,
    parameter int unsigned GAP_CYCLES  = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [3:0] done,
    output logic       led,
    output logic       busy
);

    typedef enum logic [1:0] {
        StIdle,
        StOn,
        StOff,
        StGap
    } state_e;

    // Terminal counts, computed as unsigned 32-bit values.
    localparam logic [31:0] HalfLast = 32'(HALF_PERIOD - 1);
    localparam logic [31:0] GapLast  = 32'(GAP_CYCLES - 1);

    state_e      state_q;
    logic [31:0] phase_q;  // cycles elapsed in the current ON/OFF/GAP phase
    logic [2:0]  pulse_q;  // pulses completed in the current burst
    logic [1:0]  owner_q;  // index of the current owner
    logic [1:0]  win_idx;  // arbitration winner for the present req

`ifdef LED_BLINK_RR_EN
    logic [1:0] ptr_q;     // last winner; the search starts just after it

    // Scan from ptr+4 down to ptr+1 so that the lowest offset set last wins.
    // The 2-bit sum wraps modulo 4, and offset 4 is the pointer itself.
    always_comb begin
        win_idx = ptr_q;
        for (int j = 4; j >= 1; j--) begin
            if (req[ptr_q + 2'(j)]) begin
                win_idx = ptr_q + 2'(j);
            end
        end
    end
`else
    // Fixed priority: req[0] highest. A descending scan lets the lowest index win.
    always_comb begin
        win_idx = 2'd0;
        for (int j = 3; j >= 0; j--) begin
            if (req[j]) begin
                win_idx = 2'(j);
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            phase_q <= '0;
            pulse_q <= '0;
            owner_q <= '0;
            grant   <= '0;
            done    <= '0;
            led     <= 1'b0;
            busy    <= 1'b0;
`ifdef LED_BLINK_RR_EN
            ptr_q   <= 2'd3;
`endif
        end else begin
            done <= '0;
            unique case (state_q)
                StIdle: begin
                    if (|req) begin
                        state_q <= StOn;
                        owner_q <= win_idx;
                        grant   <= 4'b0001 << win_idx;
                        phase_q <= '0;
                        pulse_q <= '0;
                        led     <= 1'b1;
                        busy    <= 1'b1;
`ifdef LED_BLINK_RR_EN
                        ptr_q   <= win_idx;
`endif
                    end else begin
                        grant <= '0;
                        led   <= 1'b0;
                        busy  <= 1'b0;
                    end
                end

                StOn: begin
                    if (phase_q == HalfLast) begin
                        state_q <= StOff;
                        phase_q <= '0;
                        led     <= 1'b0;
                    end else begin
                        phase_q <= phase_q + 32'd1;
                    end
                end

                StOff: begin
                    if (phase_q == HalfLast) begin
                        phase_q <= '0;
                        pulse_q <= pulse_q + 3'd1;
                        // Completed pulses become pulse_q+1. Another pulse is
                        // needed while pulse_q+1 < owner+1, i.e. pulse_q < owner.
                        if (pulse_q < {1'b0, owner_q}) begin
                            state_q <= StOn;
                            led     <= 1'b1;
                        end else begin
                            state_q <= StGap;
                            done    <= 4'b0001 << owner_q;
                            grant   <= '0;
                        end
                    end else begin
                        phase_q <= phase_q + 32'd1;
                    end
                end

                StGap: begin
                    if (phase_q == GapLast) begin
                        state_q <= StIdle;
                        phase_q <= '0;
                        busy    <= 1'b0;
                    end else begin
                        phase_q <= phase_q + 32'd1;
                    end
                end

                default: begin
                    state_q <= StIdle;
                    phase_q <= '0;
                    pulse_q <= '0;
                    grant   <= '0;
                    led     <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_blink_arb.sv
// -----------------------------------------------------------------------------
// tb_led_blink_arb
//
// Directed bench for led_blink_arb with HALF_PERIOD=4 and GAP_CYCLES=3. A
// timeline model predicts every output from the cycles elapsed since the last
// grant. Literal checks pin the key cycle counts.
// -----------------------------------------------------------------------------
module tb_led_blink_arb;

    localparam int unsigned HP = 4;
    localparam int unsigned GP = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] grant;
    logic [3:0] done;
    logic       led;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;

    led_blink_arb #(
        .HALF_PERIOD (HP),
        .GAP_CYCLES  (GP)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .grant (grant),
        .done  (done),
        .led   (led),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got no event, expected one within bound (t=%0t)", name, $time);
    endtask

    // ---------------- timeline model ----------------
    // m_k counts the cycles since the grant edge. Burst cycles are
    // 0..2*HP*(o+1)-1, the gap follows for GP cycles, and the model is idle after that.
    bit m_active;
    int m_k;
    int m_owner;
    int m_ptr;

    function automatic int burst_len(input int o);
        return 2 * HP * (o + 1);
    endfunction

    function automatic int pick(input logic [3:0] r, input int p);
`ifdef LED_BLINK_RR_EN
        for (int j = 1; j <= 4; j++) begin
            if (r[(p + j) % 4]) return (p + j) % 4;
        end
`else
        for (int j = 0; j < 4; j++) begin
            if (r[j]) return j;
        end
`endif
        return 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0;
            m_k      = 0;
            m_ptr    = 3;
            m_owner  = 0;
        end else if (m_active && m_k < burst_len(m_owner) + GP) begin
            m_k++;
        end else if (req != 4'b0000) begin
            m_owner  = pick(req, m_ptr);
            m_ptr    = m_owner;
            m_active = 1'b1;
            m_k      = 0;
        end else begin
            m_active = 1'b0;
        end
    end

    always @(negedge clk) begin
        logic       e_led, e_busy;
        logic [3:0] e_grant, e_done;
        int         bl;
        bl      = burst_len(m_owner);
        e_led   = 1'b0;
        e_busy  = 1'b0;
        e_grant = 4'b0000;
        e_done  = 4'b0000;
        if (m_active && m_k < bl + GP) begin
            e_busy = 1'b1;
            if (m_k < bl) begin
                e_grant = 4'b0001 << m_owner;
                e_led   = (m_k % (2 * HP)) < HP;
            end
            if (m_k == bl) e_done = 4'b0001 << m_owner;
        end
        check("model led",   {31'd0, led},   {31'd0, e_led});
        check("model busy",  {31'd0, busy},  {31'd0, e_busy});
        check("model grant", {28'd0, grant}, {28'd0, e_grant});
        check("model done",  {28'd0, done},  {28'd0, e_done});
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_grant(input string name, input int bound);
        int cnt = 0;
        while (grant == 4'b0000 && cnt < bound) begin
            @(negedge clk);
            cnt++;
        end
        if (grant == 4'b0000) timeout_fail(name);
    endtask

    task automatic wait_idle(input string name, input int bound);
        int cnt = 0;
        while (busy && cnt < bound) begin
            @(negedge clk);
            cnt++;
        end
        if (busy) timeout_fail(name);
    endtask

    initial begin
        logic       lit_led [12];
        logic [3:0] exp_order [5];
        int         cnt;

        lit_led = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
`ifdef LED_BLINK_RR_EN
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
        exp_order = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset grant", {28'd0, grant}, 32'd0);
        check("reset busy",  {31'd0, busy},  32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single pulse for requester 0. Its timeline is fixed relative to the sampling edge.
        req = 4'b0001;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            req = 4'b0000;
            check($sformatf("r0 led n%0d", n),   {31'd0, led},   {31'd0, lit_led[n-1]});
            check($sformatf("r0 grant n%0d", n), {28'd0, grant}, (n <= 8) ? 32'h1 : 32'h0);
            check($sformatf("r0 done n%0d", n),  {28'd0, done},  (n == 9) ? 32'h1 : 32'h0);
            check($sformatf("r0 busy n%0d", n),  {31'd0, busy},  (n <= 11) ? 32'h1 : 32'h0);
        end

        // Requester 3: four pulses, with done 32 cycles after the grant.
        @(negedge clk);
        req = 4'b1000;
        wait_grant("r3 grant", 10);
        check("r3 grant value", {28'd0, grant}, 32'h8);
        req = 4'b0000;
        cnt = 0;
        while (done == 4'b0000 && cnt < 60) begin
            @(negedge clk);
            cnt++;
        end
        check("r3 done latency", cnt, 32);
        check("r3 done value", {28'd0, done}, 32'h8);
        wait_idle("r3 idle", 10);

        // All four requesters held: check the grant order.
        @(negedge clk);
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_grant($sformatf("all grant %0d", g), 80);
            check($sformatf("all order %0d", g), {28'd0, grant}, {28'd0, exp_order[g]});
            if (g == 4) req = 4'b0000;
            cnt = 0;
            while (grant != 4'b0000 && cnt < 80) begin
                @(negedge clk);
                cnt++;
            end
        end
        wait_idle("all idle", 20);

        // Requester 2 drops its request mid-burst; the burst must still finish.
        @(negedge clk);
        req = 4'b0100;
        wait_grant("r2 grant", 10);
        check("r2 grant value", {28'd0, grant}, 32'h4);
        repeat (2) @(negedge clk);
        req = 4'b0000;
        cnt = 2;
        while (done == 4'b0000 && cnt < 60) begin
            @(negedge clk);
            cnt++;
        end
        check("r2 done latency", cnt, 24);
        check("r2 done value", {28'd0, done}, 32'h4);
        wait_idle("r2 idle", 10);

        // Requester 1 is reset during its second ON phase.
        @(negedge clk);
        req = 4'b0010;
        wait_grant("r1 grant", 10);
        repeat (9) @(negedge clk);
        check("r1 second on led", {31'd0, led}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async rst led",   {31'd0, led},   32'd0);
        check("async rst grant", {28'd0, grant}, 32'd0);
        check("async rst done",  {28'd0, done},  32'd0);
        check("async rst busy",  {31'd0, busy},  32'd0);
        req = 4'b0001;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post rst grant", {28'd0, grant}, 32'h1);
        req = 4'b0000;
        wait_idle("post rst idle", 30);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
